// File: rtl/regfile_mbist_pkg.sv
// Shared types and the March C- element table for the register-file MBIST engine.
package regfile_mbist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, RD_WAIT, DONE} state_e;
  typedef enum logic [1:0] {OP_W0, OP_W1, OP_R0, OP_R1} op_e;

  localparam int unsigned NUM_ELEM = 6;

  typedef struct packed {
    logic       down;
    logic [1:0] n_ops;
    op_e        op0;
    op_e        op1;
  } elem_t;

  localparam elem_t ELEM_TBL [NUM_ELEM] = '{
    '{down: 1'b0, n_ops: 2'd1, op0: OP_W0, op1: OP_W0},
    '{down: 1'b0, n_ops: 2'd2, op0: OP_R0, op1: OP_W1},
    '{down: 1'b0, n_ops: 2'd2, op0: OP_R1, op1: OP_W0},
    '{down: 1'b1, n_ops: 2'd2, op0: OP_R0, op1: OP_W1},
    '{down: 1'b1, n_ops: 2'd2, op0: OP_R1, op1: OP_W0},
    '{down: 1'b0, n_ops: 2'd1, op0: OP_R0, op1: OP_R0}
  };

  function automatic logic op_is_read(op_e op);
    return (op == OP_R0) || (op == OP_R1);
  endfunction

  function automatic logic op_is_ones(op_e op);
    return (op == OP_W1) || (op == OP_R1);
  endfunction

endpackage

// File: rtl/regfile_mbist_addr_gen.sv
// Up/down address counter for one march element, with load-first, step and last-address flag.
module regfile_mbist_addr_gen
  import regfile_mbist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ADDR_MIN   = 1,
  parameter int unsigned ADDR_MAX   = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  load_down,
  input  logic                  step,
  input  logic                  down,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] A_MIN = ADDR_WIDTH'(ADDR_MIN);
  localparam logic [ADDR_WIDTH-1:0] A_MAX = ADDR_WIDTH'(ADDR_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_down ? A_MAX : A_MIN;
    end else if (step) begin
      addr <= down ? addr - 1'b1 : addr + 1'b1;
    end
  end

  assign last = down ? (addr == A_MIN) : (addr == A_MAX);

endmodule

// File: rtl/regfile_mbist_ctrl.sv
// March C- MBIST controller driving the register-file 1RW test port and reporting first failure.
module regfile_mbist_ctrl
  import regfile_mbist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_MIN   = 1,
  parameter int unsigned ADDR_MAX   = (1 << ADDR_WIDTH) - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  bist_o,
  output logic                  csn_t_o,
  output logic                  wen_t_o,
  output logic [ADDR_WIDTH-1:0] a_t_o,
  output logic [DATA_WIDTH-1:0] d_t_o,
  input  logic [DATA_WIDTH-1:0] q_t_i,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [2:0]            fail_elem_o,
  output logic [DATA_WIDTH-1:0] fail_data_o
);

  state_e                state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic                  op_idx_q, op_idx_d;
  logic                  pass_d, fail_cap, fail_clr, adv;
  logic                  ag_load, ag_load_down, ag_step, ag_last;
  logic [ADDR_WIDTH-1:0] addr;
  elem_t                 cur;
  op_e                   op;
  logic                  last_op;
  logic [DATA_WIDTH-1:0] pattern;

  assign cur     = ELEM_TBL[elem_q];
  assign op      = op_idx_q ? cur.op1 : cur.op0;
  assign last_op = ({1'b0, op_idx_q} == (cur.n_ops - 2'd1));
  assign pattern = op_is_ones(op) ? '1 : '0;

  // Loading uses the incoming element's direction; stepping and the last flag use the current one.
  regfile_mbist_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .ADDR_MIN  (ADDR_MIN),
    .ADDR_MAX  (ADDR_MAX)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (ag_load),
    .load_down(ag_load_down),
    .step     (ag_step),
    .down     (cur.down),
    .addr     (addr),
    .last     (ag_last)
  );

  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    op_idx_d     = op_idx_q;
    pass_d       = pass_o;
    fail_cap     = 1'b0;
    fail_clr     = 1'b0;
    adv          = 1'b0;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_step      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d      = RUN;
          elem_d       = '0;
          op_idx_d     = 1'b0;
          pass_d       = 1'b0;
          fail_clr     = 1'b1;
          ag_load      = 1'b1;
          ag_load_down = ELEM_TBL[0].down;
        end
      end
      RUN: begin
        if (op_is_read(op)) state_d = RD_WAIT;
        else                adv     = 1'b1;
      end
      RD_WAIT: begin
        if (q_t_i != pattern) begin
          fail_cap = 1'b1;
          pass_d   = 1'b0;
          state_d  = DONE;
        end else begin
          state_d = RUN;
          adv     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (adv) begin
      if (!last_op) begin
        op_idx_d = 1'b1;
      end else begin
        op_idx_d = 1'b0;
        if (!ag_last) begin
          ag_step = 1'b1;
        end else if (elem_q == 3'(NUM_ELEM - 1)) begin
          state_d = DONE;
          pass_d  = 1'b1;
        end else begin
          elem_d       = elem_q + 3'd1;
          ag_load      = 1'b1;
          ag_load_down = ELEM_TBL[elem_q + 3'd1].down;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      elem_q      <= '0;
      op_idx_q    <= 1'b0;
      pass_o      <= 1'b0;
      fail_addr_o <= '0;
      fail_elem_o <= '0;
      fail_data_o <= '0;
    end else begin
      state_q  <= state_d;
      elem_q   <= elem_d;
      op_idx_q <= op_idx_d;
      pass_o   <= pass_d;
      if (fail_clr) begin
        fail_addr_o <= '0;
        fail_elem_o <= '0;
        fail_data_o <= '0;
      end else if (fail_cap) begin
        fail_addr_o <= addr;
        fail_elem_o <= elem_q;
        fail_data_o <= q_t_i;
      end
    end
  end

  assign busy_o  = (state_q == RUN) || (state_q == RD_WAIT);
  assign bist_o  = busy_o;
  assign done_o  = (state_q == DONE);
  assign csn_t_o = (state_q != RUN);
  assign wen_t_o = !((state_q == RUN) && !op_is_read(op));
  assign a_t_o   = busy_o ? addr : '0;
  assign d_t_o   = !wen_t_o ? pattern : '0;

endmodule

// File: tb/tb_regfile_mbist_ctrl.sv
// Self-checking bench for regfile_mbist_ctrl: behavioural wrapper with stuck-at faults and an op-stream scoreboard.
module tb_regfile_mbist_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst, start_i;
  logic          busy_o, done_o, pass_o, bist_o, csn_t_o, wen_t_o;
  logic [AW-1:0] a_t_o, fail_addr_o;
  logic [DW-1:0] d_t_o, fail_data_o;
  logic [DW-1:0] q_t_i = '0;
  logic [2:0]    fail_elem_o;

  typedef struct {
    bit          we;
    bit [AW-1:0] a;
    bit [DW-1:0] d;
    int unsigned cyc;
  } sb_t;

  sb_t         sb_q[$];
  sb_t         me;
  bit [DW-1:0] mem [32];
  bit [DW-1:0] sa1 [32];
  bit [DW-1:0] sa0 [32];
  bit          mon_en = 1'b0;
  int unsigned cyc, popped;
  int unsigned checks = 0;
  int unsigned passes = 0;

  always #5 clk = ~clk;

  regfile_mbist_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ADDR_MIN  (1),
    .ADDR_MAX  (31)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .pass_o     (pass_o),
    .bist_o     (bist_o),
    .csn_t_o    (csn_t_o),
    .wen_t_o    (wen_t_o),
    .a_t_o      (a_t_o),
    .d_t_o      (d_t_o),
    .q_t_i      (q_t_i),
    .fail_addr_o(fail_addr_o),
    .fail_elem_o(fail_elem_o),
    .fail_data_o(fail_data_o)
  );

  // Behavioural wrapper: read address latched at the clock ending the read cycle.
  always @(posedge clk) begin
    if (bist_o && !csn_t_o) begin
      if (!wen_t_o) mem[a_t_o] <= d_t_o;
      else          q_t_i <= (mem[a_t_o] | sa1[a_t_o]) & ~sa0[a_t_o];
    end
  end

  // Scoreboard consumer: every issued op must match the next expected op and its cycle.
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      cyc++;
      if (!csn_t_o) begin
        checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL op_stream cyc=%0d got unexpected op a=%0d we=%0b, required no op", cyc, a_t_o, !wen_t_o);
          mon_en = 1'b0;
        end else begin
          me = sb_q.pop_front();
          popped++;
          if (me.cyc !== cyc || me.we !== !wen_t_o || me.a !== a_t_o ||
              (me.we && me.d !== d_t_o) || bist_o !== 1'b1) begin
            $display("FAIL op_stream got cyc=%0d we=%0b a=%0d d=%h bist=%0b, required cyc=%0d we=%0b a=%0d d=%h bist=1",
                     cyc, !wen_t_o, a_t_o, d_t_o, bist_o, me.cyc, me.we, me.a, me.d);
            mon_en = 1'b0;
          end else begin
            passes++;
          end
        end
      end
    end
  end

  // Expected March C- op stream: 0=w0 1=w1 2=r0 3=r1; reads occupy two cycles.
  task automatic push_march();
    int unsigned c = 1;
    int          code [6][2] = '{'{0, 0}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, 2}};
    int          nops [6]    = '{1, 2, 2, 2, 2, 1};
    bit          dn   [6]    = '{0, 0, 0, 1, 1, 0};
    sb_t         e;
    sb_q.delete();
    for (int el = 0; el < 6; el++)
      for (int k = 0; k < 31; k++)
        for (int o = 0; o < nops[el]; o++) begin
          e.a   = dn[el] ? AW'(31 - k) : AW'(1 + k);
          e.we  = (code[el][o] < 2);
          e.d   = (code[el][o] % 2 == 1) ? '1 : '0;
          e.cyc = c;
          c     = c + (e.we ? 1 : 2);
          sb_q.push_back(e);
        end
  endtask

  task automatic start_run(input bit hold);
    @(negedge clk);
    push_march();
    cyc     = 0;
    popped  = 0;
    mon_en  = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    if (!hold) start_i = 1'b0;
  endtask

  task automatic wait_done(output int unsigned n);
    n = 1;
    while (!done_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bist_o, csn_t_o, wen_t_o, busy_o, done_o, pass_o} !== 6'b011000) begin
      $display("FAIL reset_ctl got %b required 011000", {bist_o, csn_t_o, wen_t_o, busy_o, done_o, pass_o});
    end else passes++;
    checks++;
    if ({a_t_o, d_t_o, fail_addr_o, fail_elem_o, fail_data_o} !== '0) begin
      $display("FAIL reset_data got a=%0d d=%h fa=%0d fe=%0d fd=%h required all 0", a_t_o, d_t_o, fail_addr_o, fail_elem_o, fail_data_o);
    end else passes++;
    rst = 1'b0;
  endtask

  task automatic test_clean_run();
    int unsigned n;
    start_run(1'b0);
    checks++;
    if ({bist_o, busy_o, done_o} !== 3'b110) begin
      $display("FAIL clean_cycle1 got bist/busy/done=%b required 110", {bist_o, busy_o, done_o});
    end else passes++;
    wait_done(n);
    checks++;
    if (n !== 466) $display("FAIL clean_done_cycle got %0d required 466", n);
    else passes++;
    checks++;
    if ({pass_o, bist_o, busy_o} !== 3'b100) begin
      $display("FAIL clean_result got pass/bist/busy=%b required 100", {pass_o, bist_o, busy_o});
    end else passes++;
    checks++;
    if (sb_q.size() !== 0) $display("FAIL clean_ops_left got %0d required 0", sb_q.size());
    else passes++;
    mon_en = 1'b0;
  endtask

  task automatic test_sa1_e1();
    int unsigned n;
    sa1[7] = 32'h0000_0008;
    start_run(1'b0);
    wait_done(n);
    checks++;
    if (n !== 52) $display("FAIL sa1_done_cycle got %0d required 52", n);
    else passes++;
    checks++;
    if ({fail_addr_o, fail_elem_o, fail_data_o} !== {5'd7, 3'd1, 32'h0000_0008}) begin
      $display("FAIL sa1_fail_info got a=%0d e=%0d d=%h required a=7 e=1 d=00000008", fail_addr_o, fail_elem_o, fail_data_o);
    end else passes++;
    checks++;
    if ({pass_o, done_o, bist_o} !== 3'b010) begin
      $display("FAIL sa1_status got pass/done/bist=%b required 010", {pass_o, done_o, bist_o});
    end else passes++;
    checks++;
    if (popped !== 44) $display("FAIL sa1_ops_issued got %0d required 44", popped);
    else passes++;
    sa1[7] = '0;
    mon_en = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_sa0_e2();
    int unsigned n;
    sa0[31] = 32'h0000_0001;
    start_run(1'b0);
    wait_done(n);
    checks++;
    if (n !== 217) $display("FAIL sa0_done_cycle got %0d required 217", n);
    else passes++;
    checks++;
    if ({fail_addr_o, fail_elem_o, fail_data_o, pass_o} !== {5'd31, 3'd2, 32'hFFFF_FFFE, 1'b0}) begin
      $display("FAIL sa0_fail_info got a=%0d e=%0d d=%h pass=%0b required a=31 e=2 d=fffffffe pass=0",
               fail_addr_o, fail_elem_o, fail_data_o, pass_o);
    end else passes++;
    checks++;
    if (popped !== 154) $display("FAIL sa0_ops_issued got %0d required 154", popped);
    else passes++;
    sa0[31] = '0;
    mon_en = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_reset_mid_run();
    int unsigned n = 1;
    start_run(1'b0);
    while (n < 100) begin
      @(negedge clk);
      n++;
    end
    rst    = 1'b1;
    mon_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({bist_o, csn_t_o, wen_t_o, busy_o, done_o, pass_o} !== 6'b011000) begin
      $display("FAIL midrst_ctl got %b required 011000", {bist_o, csn_t_o, wen_t_o, busy_o, done_o, pass_o});
    end else passes++;
    checks++;
    if ({a_t_o, d_t_o, fail_addr_o, fail_elem_o, fail_data_o} !== '0) begin
      $display("FAIL midrst_data got a=%0d d=%h fa=%0d fe=%0d fd=%h required all 0", a_t_o, d_t_o, fail_addr_o, fail_elem_o, fail_data_o);
    end else passes++;
    rst = 1'b0;
    start_run(1'b0);
    wait_done(n);
    checks++;
    if ({n == 466, pass_o, sb_q.size() == 0} !== 3'b111) begin
      $display("FAIL midrst_rerun got done_cycle=%0d pass=%0b ops_left=%0d required 466 1 0", n, pass_o, sb_q.size());
    end else passes++;
    mon_en = 1'b0;
  endtask

  task automatic test_start_held();
    int unsigned n;
    sa1[7] = 32'h0000_0008;
    start_run(1'b1);
    wait_done(n);
    checks++;
    if ({n == 52, fail_addr_o} !== {1'b1, 5'd7}) begin
      $display("FAIL held_first_run got done_cycle=%0d fa=%0d required 52 7", n, fail_addr_o);
    end else passes++;
    sa1[7] = '0;
    push_march();
    cyc    = 0;
    popped = 0;
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if ({done_o, busy_o, pass_o} !== 3'b010) begin
      $display("FAIL held_restart got done/busy/pass=%b required 010", {done_o, busy_o, pass_o});
    end else passes++;
    checks++;
    if ({fail_addr_o, fail_elem_o, fail_data_o} !== '0) begin
      $display("FAIL held_fail_clear got a=%0d e=%0d d=%h required 0", fail_addr_o, fail_elem_o, fail_data_o);
    end else passes++;
    start_i = 1'b0;
    wait_done(n);
    checks++;
    if ({n == 466, pass_o, sb_q.size() == 0} !== 3'b111) begin
      $display("FAIL held_second_run got done_cycle=%0d pass=%0b ops_left=%0d required 466 1 0", n, pass_o, sb_q.size());
    end else passes++;
    mon_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    test_reset();
    test_clean_run();
    test_sa1_e1();
    test_sa0_e2();
    test_reset_mid_run();
    test_start_held();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
